// File: rtl/su_adder_pkg.sv
// rtl/su_adder_pkg.sv - shared mode encodings and node indexing helper for the reduction tree
package su_adder_pkg;

    // Per-node operation select
    localparam logic [1:0] MODE_LEFT  = 2'b00;
    localparam logic [1:0] MODE_RIGHT = 2'b01;
    localparam logic [1:0] MODE_ADD   = 2'b10;
    localparam logic [1:0] MODE_ZERO  = 2'b11;

    // First flat node index of a tree level; level l holds num_in>>(l+1) nodes,
    // so the levels before it hold num_in - (num_in>>l) nodes in total.
    function automatic int node_base(input int level, input int num_in);
        return num_in - (num_in >> level);
    endfunction

endpackage

// File: rtl/basic_adder.sv
// rtl/basic_adder.sv - single reduction tree node: left, right, left+right or zero
module basic_adder
    import su_adder_pkg::*;
#(
    parameter int DATA_BITWIDTH = 16
) (
    input  logic [DATA_BITWIDTH-1:0] left_i,
    input  logic [DATA_BITWIDTH-1:0] right_i,
    input  logic [1:0]               mode_i,
    output logic [DATA_BITWIDTH-1:0] sum_o
);

    // Mode select; the sum wraps at the operand width
    always_comb begin
        sum_o = '0;
        case (mode_i)
            MODE_LEFT:  sum_o = left_i;
            MODE_RIGHT: sum_o = right_i;
            MODE_ADD:   sum_o = left_i + right_i;
            default:    sum_o = '0;
        endcase
    end

endmodule

// File: rtl/su_adder_v2.sv
// rtl/su_adder_v2.sv - pipelined mode-selectable reduction tree with flow control and accumulator
module su_adder_v2
    import su_adder_pkg::*;
#(
    parameter  int DATA_BITWIDTH = 16,
    parameter  int NUM_IN        = 8,
    localparam int LEVELS        = $clog2(NUM_IN)
) (
    input  logic                            clk,
    input  logic                            rst,
    input  logic                            in_valid,
    output logic                            in_ready,
    input  logic [NUM_IN*DATA_BITWIDTH-1:0] in_data,
    input  logic [2*(NUM_IN-1)-1:0]         in_mode,
    input  logic                            in_acc_en,
    output logic                            out_valid,
    input  logic                            out_ready,
    output logic [DATA_BITWIDTH-1:0]        out_data
);

    localparam int W  = DATA_BITWIDTH;
    localparam int MW = 2 * (NUM_IN - 1);

    logic         stall;
    logic         accept;
    logic         out_valid_q;
    logic [W-1:0] out_data_q;
    logic         root_vld;
    logic         root_acc;
    logic [W-1:0] root_data;

    // A held result that downstream refuses freezes the whole pipe
    assign stall     = out_valid_q & ~out_ready;
    assign in_ready  = ~stall;
    assign accept    = in_valid & in_ready;
    assign out_valid = out_valid_q;
    assign out_data  = out_data_q;

    for (genvar l = 0; l < LEVELS; l++) begin : g_stage
        localparam int NN = NUM_IN >> (l + 1);
        localparam int NB = node_base(l, NUM_IN);

        logic [W-1:0] res_d [NN];
        logic [W-1:0] res_q [NN];
        logic         vld_q;
        logic         acc_q;
        logic         vld_in;
        logic         acc_in;

        if (l == 0) begin : g_src
            assign vld_in = accept;
            assign acc_in = in_acc_en;
        end else begin : g_src
            assign vld_in = g_stage[l-1].vld_q;
            assign acc_in = g_stage[l-1].acc_q;
        end

        for (genvar k = 0; k < NN; k++) begin : g_node
            logic [W-1:0] node_l;
            logic [W-1:0] node_r;
            logic [1:0]   node_m;

            if (l == 0) begin : g_in
                assign node_l = in_data[(2*k)*W +: W];
                assign node_r = in_data[(2*k+1)*W +: W];
                assign node_m = in_mode[2*(NB+k) +: 2];
            end else begin : g_in
                assign node_l = g_stage[l-1].res_q[2*k];
                assign node_r = g_stage[l-1].res_q[2*k+1];
                assign node_m = g_stage[l-1].g_mode.mode_q[2*(NB+k) +: 2];
            end

            basic_adder #(
                .DATA_BITWIDTH(W)
            ) u_node (
                .left_i  (node_l),
                .right_i (node_r),
                .mode_i  (node_m),
                .sum_o   (res_d[k])
            );
        end

        // Only the modes of levels still ahead travel with the beat
        if (l < LEVELS - 1) begin : g_mode
            localparam int LO = 2 * node_base(l + 1, NUM_IN);

            logic [MW-1:LO] mode_q;
            logic [MW-1:LO] mode_in;

            if (l == 0) begin : g_msrc
                assign mode_in = in_mode[MW-1:LO];
            end else begin : g_msrc
                assign mode_in = g_stage[l-1].g_mode.mode_q[MW-1:LO];
            end

            // Capture the remaining modes alongside a valid beat
            always_ff @(posedge clk) begin
                if (!rst && !stall && vld_in) begin
                    mode_q <= mode_in;
                end
            end
        end

        // Level register: valid clears on reset, payload loads only with a valid beat
        always_ff @(posedge clk) begin
            if (rst) begin
                vld_q <= 1'b0;
            end else if (!stall) begin
                vld_q <= vld_in;
                if (vld_in) begin
                    res_q <= res_d;
                    acc_q <= acc_in;
                end
            end
        end
    end

    assign root_vld  = g_stage[LEVELS-1].vld_q;
    assign root_acc  = g_stage[LEVELS-1].acc_q;
    assign root_data = g_stage[LEVELS-1].res_q[0];

    // Output register doubles as the accumulator; it keeps its value across bubbles
    always_ff @(posedge clk) begin
        if (rst) begin
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
        end else if (!stall) begin
            if (root_vld) begin
                out_data_q  <= root_acc ? (out_data_q + root_data) : root_data;
                out_valid_q <= 1'b1;
            end else begin
                out_valid_q <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_su_adder_v2.sv
// tb/tb_su_adder_v2.sv - directed self-checking bench for su_adder_v2
module tb_su_adder_v2;

    localparam int W  = 16;
    localparam int N  = 8;
    localparam int MW = 2 * (N - 1);

    localparam logic [MW-1:0] M_ALL_ADD  = 14'h2AAA;
    localparam logic [MW-1:0] M_ROOT_L   = 14'h0AAA;
    localparam logic [MW-1:0] M_ROOT_Z   = 14'h3AAA;
    localparam logic [MW-1:0] M_LEAF0_R  = 14'h2AA9;

    logic          clk = 1'b0;
    logic          rst;
    logic          in_valid;
    logic          in_ready;
    logic [N*W-1:0] in_data;
    logic [MW-1:0] in_mode;
    logic          in_acc_en;
    logic          out_valid;
    logic          out_ready;
    logic [W-1:0]  out_data;

    int checks = 0;
    int passed = 0;

    always #5 clk = ~clk;

    su_adder_v2 #(
        .DATA_BITWIDTH(W),
        .NUM_IN(N)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .in_mode   (in_mode),
        .in_acc_en (in_acc_en),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        assert (got === exp) passed++;
        else $error("FAIL %s: got %0h expected %0h", tag, got, exp);
    endtask

    // Operand j = base + j
    function automatic logic [N*W-1:0] seq(input int base);
        logic [N*W-1:0] v;
        v = '0;
        for (int j = 0; j < N; j++) v[j*W +: W] = W'(base + j);
        return v;
    endfunction

    // One isolated beat, checked for exact latency and value
    task automatic run_one(input string tag, input logic [N*W-1:0] data,
                           input logic [MW-1:0] mode, input logic acc, input int exp);
        in_data   = data;
        in_mode   = mode;
        in_acc_en = acc;
        in_valid  = 1'b1;
        tick();
        in_valid  = 1'b0;
        chk({tag, "_v1"}, 32'(out_valid), 0);
        tick();
        chk({tag, "_v2"}, 32'(out_valid), 0);
        tick();
        chk({tag, "_v3"}, 32'(out_valid), 0);
        tick();
        chk({tag, "_v4"}, 32'(out_valid), 1);
        chk({tag, "_data"}, 32'(out_data), 32'(exp));
        tick();
    endtask

    initial begin
        int sent;
        int recv;
        int stale;
        logic acc_now;
        logic [W-1:0] held;

        rst       = 1'b1;
        in_valid  = 1'b0;
        in_data   = '0;
        in_mode   = '0;
        in_acc_en = 1'b0;
        out_ready = 1'b1;
        tick();
        tick();
        chk("rst_out_valid", 32'(out_valid), 0);
        chk("rst_out_data", 32'(out_data), 0);
        chk("rst_in_ready", 32'(in_ready), 1);
        rst = 1'b0;
        tick();

        run_one("sum36", seq(1), M_ALL_ADD, 1'b0, 36);
        run_one("root_left", seq(1), M_ROOT_L, 1'b0, 10);
        run_one("root_zero", seq(1), M_ROOT_Z, 1'b0, 0);
        // node 0 forwards operand 1 (=2) and drops operand 0 (=1)
        run_one("leaf0_right", seq(1), M_LEAF0_R, 1'b0, 35);
        run_one("wrap", '1, M_ALL_ADD, 1'b0, 32'hFFF8);

        // Back-to-back beats with acc_en 0,1,0
        in_data  = seq(1);
        in_mode  = M_ALL_ADD;
        in_valid = 1'b1;
        in_acc_en = 1'b0;
        tick();
        in_acc_en = 1'b1;
        tick();
        in_acc_en = 1'b0;
        tick();
        in_valid = 1'b0;
        tick();
        chk("acc_b0_v", 32'(out_valid), 1);
        chk("acc_b0", 32'(out_data), 36);
        tick();
        chk("acc_b1", 32'(out_data), 72);
        tick();
        chk("acc_b2", 32'(out_data), 36);
        tick();
        chk("acc_idle_v", 32'(out_valid), 0);

        // Bubble between the base beat and the accumulating beat
        in_valid  = 1'b1;
        in_acc_en = 1'b0;
        tick();
        in_valid  = 1'b0;
        tick();
        in_valid  = 1'b1;
        in_acc_en = 1'b1;
        tick();
        in_valid  = 1'b0;
        in_acc_en = 1'b0;
        tick();
        chk("bub_b0", 32'(out_data), 36);
        tick();
        chk("bub_gap_v", 32'(out_valid), 0);
        chk("bub_gap_hold", 32'(out_data), 36);
        tick();
        chk("bub_b1_v", 32'(out_valid), 1);
        chk("bub_b1", 32'(out_data), 72);
        tick();

        // Six beats, downstream refuses during cycles 4..6
        sent = 0;
        recv = 0;
        held = '0;
        for (int cyc = 0; cyc < 30; cyc++) begin
            out_ready = !(cyc >= 4 && cyc <= 6);
            in_valid  = (sent < 6);
            in_data   = seq(sent + 1);
            in_mode   = M_ALL_ADD;
            in_acc_en = 1'b0;
            @(negedge clk);
            if (cyc == 4) begin
                held = out_data;
                chk("stall_in_ready_c4", 32'(in_ready), 0);
                chk("stall_held_first", 32'(held), 36);
            end
            if (cyc == 5 || cyc == 6) begin
                chk("stall_in_ready", 32'(in_ready), 0);
                chk("stall_data_stable", 32'(out_data), 32'(held));
            end
            acc_now = in_valid && in_ready;
            if (out_valid && out_ready) begin
                chk("stream_order", 32'(out_data), 32'(36 + 8 * recv));
                recv++;
            end
            tick();
            if (acc_now) sent++;
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        chk("stream_sent", 32'(sent), 6);
        chk("stream_recv", 32'(recv), 6);

        // Reset with beats in flight and a valid result on the output
        in_data   = seq(1);
        in_mode   = M_ALL_ADD;
        in_acc_en = 1'b0;
        in_valid  = 1'b1;
        tick();
        tick();
        tick();
        tick();
        in_valid = 1'b0;
        chk("pre_rst_v", 32'(out_valid), 1);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("mid_rst_v", 32'(out_valid), 0);
        chk("mid_rst_data", 32'(out_data), 0);
        stale = 0;
        for (int i = 0; i < 6; i++) begin
            tick();
            if (out_valid) stale++;
        end
        chk("no_stale", 32'(stale), 0);
        // Accumulating beat proves the accumulator was cleared
        run_one("post_rst", seq(2), M_ALL_ADD, 1'b1, 44);

        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
